// File: rtl/hazard_pkg.sv
// Shared pipeline-control types: hazard FSM states and write-back source selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    BUSY  = 2'd2
  } hz_state_t;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the five-stage pipeline: load-use stalls, redirect
// flushes stretched over imem latency, multi-cycle EX holds and perf counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  input  logic                 rs1_used_ID,
  input  logic                 rs2_used_ID,
  input  logic [4:0]           rd_IDEX,
  input  logic                 reg_wr_en_IDEX,
  input  logic [1:0]           reg_wr_ctrl_IDEX,
  input  logic                 pc_sel_EXIF,
  input  logic                 ex_busy,
  output logic                 stall_IF,
  output logic                 stall_IFID,
  output logic                 stall_IDEX,
  output logic                 flush_IFID,
  output logic                 flush_IDEX,
  output logic                 bubble_EXMEM,
  output logic                 busy_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam int              BW         = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BW-1:0]   BUSY_MAX   = BW'(BUSY_TIMEOUT);
  localparam logic [2:0]      FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

  hz_state_t     state, state_nxt;
  logic [2:0]    fcnt, fcnt_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          timeout_set;
  logic          lu;

  assign lu = reg_wr_en_IDEX && (reg_wr_ctrl_IDEX == WB_SEL_MEM) && (rd_IDEX != 5'd0) &&
              ((rs1_used_ID && (rs1_ID == rd_IDEX)) || (rs2_used_ID && (rs2_ID == rd_IDEX)));

  // Control outputs in priority order; reset forces every control low.
  always_comb begin
    stall_IF     = 1'b0;
    stall_IFID   = 1'b0;
    stall_IDEX   = 1'b0;
    flush_IFID   = 1'b0;
    flush_IDEX   = 1'b0;
    bubble_EXMEM = 1'b0;
    if (!reset) begin
      stall_IF = 1'b0;
    end else if (pc_sel_EXIF) begin
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end else if (state == FLUSH) begin
      flush_IFID = 1'b1;
    end else if (ex_busy) begin
      stall_IF     = 1'b1;
      stall_IFID   = 1'b1;
      stall_IDEX   = 1'b1;
      bubble_EXMEM = 1'b1;
    end else if (lu) begin
      stall_IF   = 1'b1;
      stall_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    bcnt_nxt    = bcnt;
    timeout_set = 1'b0;
    if (pc_sel_EXIF) begin
      bcnt_nxt  = '0;
      fcnt_nxt  = FLUSH_LOAD;
      state_nxt = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
    end else begin
      case (state)
        RUN: begin
          if (ex_busy) begin
            state_nxt = BUSY;
            bcnt_nxt  = BW'(1);
          end
        end
        FLUSH: begin
          if (fcnt == 3'd0) begin
            if (ex_busy) begin
              state_nxt = BUSY;
              bcnt_nxt  = BW'(1);
            end else begin
              state_nxt = RUN;
            end
          end else begin
            fcnt_nxt = fcnt - 1'b1;
          end
        end
        BUSY: begin
          // A busy cycle beyond the legal maximum raises the flag; the stall itself continues.
          if (ex_busy) begin
            if (bcnt == BUSY_MAX) begin
              timeout_set = 1'b1;
            end else begin
              bcnt_nxt = bcnt + 1'b1;
            end
          end else begin
            state_nxt = RUN;
            bcnt_nxt  = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          fcnt_nxt  = 3'd0;
          bcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      fcnt         <= 3'd0;
      bcnt         <= '0;
      busy_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      bcnt  <= bcnt_nxt;
      if (timeout_set) begin
        busy_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_IF),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_sel_EXIF),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: dut_a (FLUSH_CYCLES=2) for control/counter behaviour, dut_b
// (BUSY_TIMEOUT=4, 4-bit counters) for timeout and counter saturation.
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_BUSY  = 6'b111001;
  localparam logic [5:0] C_REDIR = 6'b000110;
  localparam logic [5:0] C_FLUSH = 6'b000100;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_ID, rs2_ID, rd_IDEX;
  logic       rs1_used_ID, rs2_used_ID, reg_wr_en_IDEX;
  logic [1:0] reg_wr_ctrl_IDEX;
  logic       pc_sel_EXIF, ex_busy;

  logic        a_stall_IF, a_stall_IFID, a_stall_IDEX, a_flush_IFID, a_flush_IDEX, a_bubble;
  logic        a_timeout;
  logic [31:0] a_stall_cycles, a_flush_events;
  logic        b_stall_IF, b_stall_IFID, b_stall_IDEX, b_flush_IFID, b_flush_IDEX, b_bubble;
  logic        b_timeout;
  logic [3:0]  b_stall_cycles, b_flush_events;
  logic [5:0]  ctrl_a;

  int vector_count     = 0;
  int miscompare_count = 0;
  int exp_stall        = 0;

  assign ctrl_a = {a_stall_IF, a_stall_IFID, a_stall_IDEX, a_flush_IFID, a_flush_IDEX, a_bubble};

  hazard_control_unit #(.FLUSH_CYCLES(2), .BUSY_TIMEOUT(64), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_IDEX(rd_IDEX), .reg_wr_en_IDEX(reg_wr_en_IDEX), .reg_wr_ctrl_IDEX(reg_wr_ctrl_IDEX),
    .pc_sel_EXIF(pc_sel_EXIF), .ex_busy(ex_busy),
    .stall_IF(a_stall_IF), .stall_IFID(a_stall_IFID), .stall_IDEX(a_stall_IDEX),
    .flush_IFID(a_flush_IFID), .flush_IDEX(a_flush_IDEX), .bubble_EXMEM(a_bubble),
    .busy_timeout(a_timeout), .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
  );

  hazard_control_unit #(.FLUSH_CYCLES(1), .BUSY_TIMEOUT(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_IDEX(rd_IDEX), .reg_wr_en_IDEX(reg_wr_en_IDEX), .reg_wr_ctrl_IDEX(reg_wr_ctrl_IDEX),
    .pc_sel_EXIF(pc_sel_EXIF), .ex_busy(ex_busy),
    .stall_IF(b_stall_IF), .stall_IFID(b_stall_IFID), .stall_IDEX(b_stall_IDEX),
    .flush_IFID(b_flush_IFID), .flush_IDEX(b_flush_IDEX), .bubble_EXMEM(b_bubble),
    .busy_timeout(b_timeout), .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pc, input logic busy, input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                               input logic [1:0] wb);
    pc_sel_EXIF      = pc;
    ex_busy          = busy;
    rs1_ID           = r1;
    rs2_ID           = r2;
    rs1_used_ID      = u1;
    rs2_used_ID      = u2;
    rd_IDEX          = rd;
    reg_wr_en_IDEX   = we;
    reg_wr_ctrl_IDEX = wb;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
  endtask

  // Load in EX writes x5, decoded instruction reads x5 through rs2.
  task automatic loadUse(input logic pc, input logic busy);
    applyStimulus(pc, busy, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, WB_SEL_MEM);
  endtask

  task automatic runBusy(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
      #1 checkOutput("busy_ctrl", 64'(ctrl_a), 64'(C_BUSY));
    end
    exp_stall += n;
    step();
    idle();
    #1 checkOutput("busy_release", 64'(ctrl_a), 64'(C_NONE));
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) step();
    #1;
    checkOutput("rst_ctrl", 64'(ctrl_a), 64'(C_NONE));
    checkOutput("rst_stall_cnt", 64'(a_stall_cycles), 64'd0);
    checkOutput("rst_flush_cnt", 64'(a_flush_events), 64'd0);
    checkOutput("rst_timeout", 64'(b_timeout), 64'd0);
    loadUse(1'b1, 1'b1);
    #1 checkOutput("rst_forced_ctrl", 64'(ctrl_a), 64'(C_NONE));
    step();
    #1 checkOutput("rst_flush_cnt_held", 64'(a_flush_events), 64'd0);
    idle();
    step();
    reset = 1'b1;

    step(); loadUse(1'b0, 1'b0);
    #1 checkOutput("lu_rs2", 64'(ctrl_a), 64'(C_LU));
    exp_stall++;
    step(); idle();
    #1 checkOutput("lu_one_cycle", 64'(ctrl_a), 64'(C_NONE));
    checkOutput("lu_stall_cnt", 64'(a_stall_cycles), 64'(exp_stall));

    step(); applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, WB_SEL_MEM);
    #1 checkOutput("nolu_rd0", 64'(ctrl_a), 64'(C_NONE));
    step(); applyStimulus(1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, WB_SEL_MEM);
    #1 checkOutput("nolu_rs1_unused", 64'(ctrl_a), 64'(C_NONE));
    step(); applyStimulus(1'b0, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, WB_SEL_ALU);
    #1 checkOutput("nolu_wb_alu", 64'(ctrl_a), 64'(C_NONE));
    step(); applyStimulus(1'b0, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, WB_SEL_MEM);
    #1 checkOutput("nolu_no_wr", 64'(ctrl_a), 64'(C_NONE));
    step(); applyStimulus(1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, WB_SEL_MEM);
    #1 checkOutput("lu_rs1", 64'(ctrl_a), 64'(C_LU));
    exp_stall++;
    step(); idle();
    #1 checkOutput("lu_rs1_stall_cnt", 64'(a_stall_cycles), 64'(exp_stall));

    step(); applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
    #1 checkOutput("redir_T", 64'(ctrl_a), 64'(C_REDIR));
    step(); loadUse(1'b0, 1'b0);
    #1 checkOutput("redir_T1", 64'(ctrl_a), 64'(C_FLUSH));
    step();
    #1 checkOutput("redir_T2", 64'(ctrl_a), 64'(C_FLUSH));
    step();
    #1 checkOutput("redir_T3_run", 64'(ctrl_a), 64'(C_LU));
    exp_stall++;
    step(); idle();
    #1 checkOutput("redir_flush_cnt", 64'(a_flush_events), 64'd1);
    checkOutput("redir_stall_cnt", 64'(a_stall_cycles), 64'(exp_stall));

    runBusy(4);
    checkOutput("tmo_b_at_limit", 64'(b_timeout), 64'd0);
    runBusy(6);
    checkOutput("tmo_b_over_limit", 64'(b_timeout), 64'd1);
    runBusy(10);
    checkOutput("busy10_stall_cnt", 64'(a_stall_cycles), 64'(exp_stall));
    checkOutput("busy10_no_tmo_a", 64'(a_timeout), 64'd0);
    checkOutput("tmo_b_sticky", 64'(b_timeout), 64'd1);
    checkOutput("b_stall_saturated", 64'(b_stall_cycles), 64'hF);

    step(); loadUse(1'b1, 1'b1);
    #1 checkOutput("prio_all", 64'(ctrl_a), 64'(C_REDIR));
    step(); loadUse(1'b0, 1'b0);
    #1 checkOutput("prio_lu_in_flush", 64'(ctrl_a), 64'(C_FLUSH));
    step(); idle();
    step();
    #1 checkOutput("prio_flush_cnt", 64'(a_flush_events), 64'd2);

    step(); applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
    #1 checkOutput("busy_before_redir", 64'(ctrl_a), 64'(C_BUSY));
    exp_stall++;
    step(); applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
    #1 checkOutput("redir_in_busy", 64'(ctrl_a), 64'(C_REDIR));
    step(); applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
    #1 checkOutput("left_busy", 64'(ctrl_a), 64'(C_FLUSH));
    step(); idle();
    #1 checkOutput("left_busy_T2", 64'(ctrl_a), 64'(C_FLUSH));
    step();
    #1 checkOutput("after_busy_redir", 64'(ctrl_a), 64'(C_NONE));
    checkOutput("busy_redir_stall_cnt", 64'(a_stall_cycles), 64'(exp_stall));
    checkOutput("busy_redir_flush_cnt", 64'(a_flush_events), 64'd3);

    for (int i = 0; i < 3; i++) begin
      step(); applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_SEL_ALU);
    end
    #1 checkOutput("pre_reset_busy", 64'(ctrl_a), 64'(C_BUSY));
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", 64'(ctrl_a), 64'(C_NONE));
    checkOutput("async_rst_stall_cnt", 64'(a_stall_cycles), 64'd0);
    checkOutput("async_rst_flush_cnt", 64'(a_flush_events), 64'd0);
    checkOutput("async_rst_tmo_b", 64'(b_timeout), 64'd0);
    step(); idle();
    step(); reset = 1'b1;
    step();
    #1 checkOutput("post_rst_ctrl", 64'(ctrl_a), 64'(C_NONE));
    step();
    #1 checkOutput("post_rst_ctrl2", 64'(ctrl_a), 64'(C_NONE));
    checkOutput("post_rst_stall_cnt", 64'(a_stall_cycles), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
